// File: rtl/match_sequencer_if.sv
// -----------------------------------------------------------------------------
// match_sequencer_if
// Bundles the game-controller signals exchanged between the match sequencer
// and the rest of the ping-pong design.
//
//   p1l/p1r/p2l/p2r   buttons, level, synchronous to clk (into sequencer)
//   miss_p1/miss_p2   one-cycle miss pulses from the ball datapath
//   game_state        0=serve 1=playing 2=done 3=point
//   frame_tick        one-cycle frame pulse
//   ball_launch       one-cycle pulse when play starts from serve
//   server            0=player 1 serves, 1=player 2 serves
//   time_cnt          seconds remaining
//   p1_score/p2_score points
//   winner            0=none 1=p1 2=p2 3=draw
//
// master: the side that drives buttons/misses and observes the game status.
// slave : the match sequencer itself.
// -----------------------------------------------------------------------------
interface match_sequencer_if;
  logic       p1l;
  logic       p1r;
  logic       p2l;
  logic       p2r;
  logic       miss_p1;
  logic       miss_p2;
  logic [1:0] game_state;
  logic       frame_tick;
  logic       ball_launch;
  logic       server;
  logic [5:0] time_cnt;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;

  modport master (
    output p1l, p1r, p2l, p2r, miss_p1, miss_p2,
    input  game_state, frame_tick, ball_launch, server,
    input  time_cnt, p1_score, p2_score, winner
  );

  modport slave (
    input  p1l, p1r, p2l, p2r, miss_p1, miss_p2,
    output game_state, frame_tick, ball_launch, server,
    output time_cnt, p1_score, p2_score, winner
  );
endinterface

// File: rtl/match_sequencer.sv
// -----------------------------------------------------------------------------
// match_sequencer
// Central game controller of the ping-pong design: serve/playing/point/done
// state machine, frame-tick and one-second timebase, countdown timer, scores,
// serve hand-off and winner decision. All outputs are registered.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    match_sequencer_if.slave (buttons and misses in, game status out)
// -----------------------------------------------------------------------------
module match_sequencer #(
  parameter int CLK_PER_TICK  = 400000,
  parameter int TICKS_PER_SEC = 125,
  parameter int GAME_SECONDS  = 60,
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_DELAY   = 60
) (
  input logic               clk,
  input logic               reset,
  match_sequencer_if.slave  bus
);

  localparam int TICK_W = (CLK_PER_TICK  > 1) ? $clog2(CLK_PER_TICK)  : 1;
  localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PT_W   = (SERVE_DELAY   > 1) ? $clog2(SERVE_DELAY)   : 1;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_PER_TICK - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX   = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [PT_W-1:0]   PT_MAX    = PT_W'(SERVE_DELAY - 1);
  localparam logic [5:0]        TIME_INIT = 6'(GAME_SECONDS);
  localparam logic [3:0]        WIN_Q     = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_SERVE   = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2,
    ST_POINT   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic [SEC_W-1:0]    sec_cnt_q,    sec_cnt_d;
  logic [PT_W-1:0]     pt_cnt_q,     pt_cnt_d;
  logic [5:0]          time_cnt_q,   time_cnt_d;
  logic [3:0]          p1_score_q,   p1_score_d;
  logic [3:0]          p2_score_q,   p2_score_d;
  logic                server_q,     server_d;
  logic                launch_q,     launch_d;
  logic [1:0]          winner_q,     winner_d;
  logic [3:0]          btn_prev_q,   btn_prev_d;

  // Button order: [3]=p1l [2]=p1r [1]=p2l [0]=p2r
  logic [3:0] btn_cur;
  logic [3:0] press;
  logic       p1_press;
  logic       p2_press;
  logic       any_miss;
  logic       single_p1;
  logic       single_p2;

  assign btn_cur   = {bus.p1l, bus.p1r, bus.p2l, bus.p2r};
  assign press     = btn_cur & ~btn_prev_q;
  assign p1_press  = |press[3:2];
  assign p2_press  = |press[1:0];
  assign any_miss  = bus.miss_p1 | bus.miss_p2;
  assign single_p1 = bus.miss_p1 & ~bus.miss_p2;
  assign single_p2 = bus.miss_p2 & ~bus.miss_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= WIN_Q) return WIN_Q;
    return s + 4'd1;
  endfunction

  function automatic logic [1:0] judge(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 2'd1;
    if (b > a) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    pt_cnt_d     = pt_cnt_q;
    time_cnt_d   = time_cnt_q;
    p1_score_d   = p1_score_q;
    p2_score_d   = p2_score_q;
    server_d     = server_q;
    winner_d     = winner_q;
    launch_d     = 1'b0;
    btn_prev_d   = btn_cur;

    // Free-running timebase; the pulse appears the cycle after the wrap.
    frame_tick_d = (tick_cnt_q == TICK_MAX);
    tick_cnt_d   = frame_tick_d ? '0 : tick_cnt_q + 1'b1;

    unique case (state_q)
      ST_SERVE: begin
        if ((!server_q && p1_press) || (server_q && p2_press)) begin
          state_d  = ST_PLAYING;
          launch_d = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (frame_tick_q) begin
          if (sec_cnt_q == SEC_MAX) begin
            sec_cnt_d = '0;
            if (time_cnt_q != 6'd0) time_cnt_d = time_cnt_q - 6'd1;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end
        // A double miss scores nobody and keeps the current server.
        if (single_p1) begin
          p2_score_d = sat_inc(p2_score_q);
          server_d   = 1'b0;
        end else if (single_p2) begin
          p1_score_d = sat_inc(p1_score_q);
          server_d   = 1'b1;
        end
        // Expiry wins over the point pause; the winner sees the updated score.
        if (time_cnt_d == 6'd0) begin
          state_d  = ST_DONE;
          winner_d = judge(p1_score_d, p2_score_d);
        end else if (any_miss) begin
          state_d  = ST_POINT;
          pt_cnt_d = '0;
        end
      end

      ST_POINT: begin
        if (frame_tick_q) begin
          if (pt_cnt_q == PT_MAX) begin
            pt_cnt_d = '0;
            if (p1_score_q == WIN_Q || p2_score_q == WIN_Q) begin
              state_d  = ST_DONE;
              winner_d = judge(p1_score_q, p2_score_q);
            end else begin
              state_d  = ST_SERVE;
            end
          end else begin
            pt_cnt_d = pt_cnt_q + 1'b1;
          end
        end
      end

      default: ; // ST_DONE is terminal until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SERVE;
      tick_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
      sec_cnt_q    <= '0;
      pt_cnt_q     <= '0;
      time_cnt_q   <= TIME_INIT;
      p1_score_q   <= 4'd0;
      p2_score_q   <= 4'd0;
      server_q     <= 1'b0;
      launch_q     <= 1'b0;
      winner_q     <= 2'd0;
      btn_prev_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      frame_tick_q <= frame_tick_d;
      sec_cnt_q    <= sec_cnt_d;
      pt_cnt_q     <= pt_cnt_d;
      time_cnt_q   <= time_cnt_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      server_q     <= server_d;
      launch_q     <= launch_d;
      winner_q     <= winner_d;
      btn_prev_q   <= btn_prev_d;
    end
  end

  assign bus.game_state  = state_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.ball_launch = launch_q;
  assign bus.server      = server_q;
  assign bus.time_cnt    = time_cnt_q;
  assign bus.p1_score    = p1_score_q;
  assign bus.p2_score    = p2_score_q;
  assign bus.winner      = winner_q;

endmodule
